// File: rtl/otter_io_pkg.sv
// otter_io_pkg
// Shared definitions for the OTTER board I/O wrapper.
//   - Memory-mapped addresses of the switch, LED and seven-segment registers.
//   - Blank patterns for the active-low anode and cathode lines.
//   - The digit-select encoding used by the display scanner.
//   - hexToCathode: maps a 4-bit nibble to its active-low segment pattern.
package otter_io_pkg;

   localparam logic [31:0] SwitchAddr   = 32'h1100_0000;
   localparam logic [31:0] LedAddr      = 32'h1108_0000;
   localparam logic [31:0] SsegAddr     = 32'h110C_0000;

   localparam logic [7:0]  CathodeBlank = 8'hFF;
   localparam logic [3:0]  AnodeBlank   = 4'hF;

   typedef enum logic [1:0] {
      Digit0 = 2'd0,
      Digit1 = 2'd1,
      Digit2 = 2'd2,
      Digit3 = 2'd3
   } digitSel_e;

   // Segment lines are active-low in {a,b,c,d,e,f,g,dp} order with a in bit 7.
   // Bit 0 (the decimal point) is 1 in every entry so the dp stays dark.
   function automatic logic [7:0] hexToCathode(input logic [3:0] nibble);
      logic [7:0] segments;
      case (nibble)
         4'h0:    segments = 8'h03;
         4'h1:    segments = 8'h9F;
         4'h2:    segments = 8'h25;
         4'h3:    segments = 8'h0D;
         4'h4:    segments = 8'h99;
         4'h5:    segments = 8'h49;
         4'h6:    segments = 8'h41;
         4'h7:    segments = 8'h1F;
         4'h8:    segments = 8'h01;
         4'h9:    segments = 8'h09;
         4'hA:    segments = 8'h11;
         4'hB:    segments = 8'hC1;
         4'hC:    segments = 8'h63;
         4'hD:    segments = 8'h85;
         4'hE:    segments = 8'h61;
         default: segments = 8'h71;
      endcase
      return segments;
   endfunction

endpackage

// File: rtl/otter_mcu.sv
// OTTER_MCU
// Minimal stand-in for the OTTER RISC-V core so that the board wrapper
// elaborates as a self-contained slice. It never issues bus cycles on its own;
// it only remembers the last IOBUS_IN value seen when an interrupt arrives.
// Ports:
//   CLK         in   system clock
//   RST         in   active-high reset
//   INTR        in   one-cycle interrupt pulse
//   IOBUS_IN    in   read data from the I/O registers
//   IOBUS_OUT   out  write data
//   IOBUS_ADDR  out  I/O address
//   IOBUS_WR    out  write strobe
module OTTER_MCU (
   input  logic        CLK,
   input  logic        RST,
   input  logic        INTR,
   input  logic [31:0] IOBUS_IN,
   output logic [31:0] IOBUS_OUT,
   output logic [31:0] IOBUS_ADDR,
   output logic        IOBUS_WR
);

   logic [31:0] lastRead;

   // Capture the I/O read data whenever an interrupt is taken; this keeps
   // every input of the core connected to some real logic.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lastRead <= '0;
      end else if (INTR) begin
         lastRead <= IOBUS_IN;
      end
   end

   assign IOBUS_OUT  = lastRead;
   assign IOBUS_ADDR = '0;
   assign IOBUS_WR   = 1'b0;

endmodule

// File: rtl/sseg_driver.sv
// sseg_driver
// Multiplexed 4-digit hex seven-segment driver. A free-running scan counter
// walks the digits; each digit is lit for 2^(REFRESH_BITS-2) cycles.
// Ports:
//   CLK       in   system clock
//   reset     in   active-high, asynchronously asserted; blanks the display
//   value     in   16-bit value, nibble n shown on digit n (digit 0 rightmost)
//   CATHODES  out  active-low segments {a,b,c,d,e,f,g,dp}
//   ANODES    out  active-low digit enables, ANODES[0] is the rightmost digit
// Parameter:
//   REFRESH_BITS  width of the scan counter; its top two bits pick the digit
module sseg_driver
   import otter_io_pkg::*;
#(
   parameter int REFRESH_BITS = 17
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic [15:0] value,
   output logic [7:0]  CATHODES,
   output logic [3:0]  ANODES
);

   logic [REFRESH_BITS-1:0] scanCount;
   digitSel_e               digitSel;
   logic [3:0]              nibble;
   logic [3:0]              anodeMask;

   // The scan counter simply counts every cycle and wraps, so one full
   // 4-digit frame takes 2^REFRESH_BITS cycles. Reset parks it at digit 0.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         scanCount <= '0;
      end else begin
         scanCount <= scanCount + REFRESH_BITS'(1);
      end
   end

   // Pick the nibble and anode for the digit currently being scanned, then
   // decode it. Reset overrides everything so the display goes dark the
   // moment reset asserts, without waiting for a clock edge.
   always_comb begin
      digitSel  = digitSel_e'(scanCount[REFRESH_BITS-1:REFRESH_BITS-2]);
      nibble    = value[3:0];
      anodeMask = 4'b1110;
      case (digitSel)
         Digit0: begin nibble = value[3:0];   anodeMask = 4'b1110; end
         Digit1: begin nibble = value[7:4];   anodeMask = 4'b1101; end
         Digit2: begin nibble = value[11:8];  anodeMask = 4'b1011; end
         Digit3: begin nibble = value[15:12]; anodeMask = 4'b0111; end
      endcase

      ANODES   = AnodeBlank;
      CATHODES = CathodeBlank;
      if (!reset) begin
         ANODES   = anodeMask;
         CATHODES = hexToCathode(nibble);
      end
   end

endmodule

// File: rtl/otter_io_wrapper.sv
// otter_io_wrapper
// Board-level wrapper between the OTTER_MCU core and the FPGA pins: reset
// conditioning, BTNL interrupt conditioning, memory-mapped switch/LED/display
// registers, the combinational read mux and the 4-digit display driver.
// Ports:
//   CLK       in   50 MHz system clock
//   BTNC      in   asynchronous active-low reset button
//   BTNL      in   active-high interrupt button, asynchronous to CLK
//   SWITCHES  in   8 slide switches
//   LEDS      out  8 LEDs
//   CATHODES  out  active-low segments {a,b,c,d,e,f,g,dp}
//   ANODES    out  active-low digit enables, ANODES[0] rightmost
// Parameters:
//   REFRESH_BITS     display scan counter width
//   DEBOUNCE_CYCLES  stable cycles BTNL needs when debouncing is built
// Configuration:
//   BTN_DEBOUNCE_EN  when defined, BTNL is debounced before edge detection;
//                    when undefined, the synchronized level is used directly.
module otter_io_wrapper
   import otter_io_pkg::*;
#(
   parameter int REFRESH_BITS    = 17,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       CLK,
   input  logic       BTNC,
   input  logic       BTNL,
   input  logic [7:0] SWITCHES,
   output logic [7:0] LEDS,
   output logic [7:0] CATHODES,
   output logic [3:0] ANODES
);

   logic [1:0]  rstSync;
   logic        reset;
   logic [7:0]  swMeta;
   logic [7:0]  swSync;
   logic [1:0]  btnSync;
   logic        edgeSrc;
   logic        edgePrev;
   logic        intr;
   logic [7:0]  ledReg;
   logic [15:0] dispValue;
   logic [31:0] iobusIn;
   logic [31:0] iobusOut;
   logic [31:0] iobusAddr;
   logic        iobusWr;

   // Reset synchronizer: pressing BTNC forces internal reset at once, while
   // release is shifted through two flops so every flop leaves reset on the
   // same clean edge.
   always_ff @(posedge CLK or negedge BTNC) begin
      if (!BTNC) begin
         rstSync <= 2'b11;
      end else begin
         rstSync <= {rstSync[0], 1'b0};
      end
   end

   assign reset = rstSync[1];

   // Two-flop synchronizers for the slide switches and the interrupt button,
   // both of which change with no relation to CLK.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         swMeta  <= '0;
         swSync  <= '0;
         btnSync <= '0;
      end else begin
         swMeta  <= SWITCHES;
         swSync  <= swMeta;
         btnSync <= {btnSync[0], BTNL};
      end
   end

`ifdef BTN_DEBOUNCE_EN
   localparam int DebounceWidth = $clog2(DEBOUNCE_CYCLES + 1);

   logic [DebounceWidth-1:0] debounceCount;
   logic                     btnStable;

   // Debounce: the accepted level only follows the synchronized button once
   // it has disagreed with it for DEBOUNCE_CYCLES cycles in a row; any bounce
   // back to the accepted level restarts the count.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         debounceCount <= '0;
         btnStable     <= 1'b0;
      end else if (btnSync[1] == btnStable) begin
         debounceCount <= '0;
      end else if (debounceCount == DebounceWidth'(DEBOUNCE_CYCLES - 1)) begin
         debounceCount <= '0;
         btnStable     <= btnSync[1];
      end else begin
         debounceCount <= debounceCount + DebounceWidth'(1);
      end
   end

   assign edgeSrc = btnStable;
`else
   assign edgeSrc = btnSync[1];
`endif

   // Rising-edge one-shot: INTR is registered, so it is high for exactly one
   // cycle per press no matter how long the button is held, and reset clears
   // any pulse that was about to fire.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         edgePrev <= 1'b0;
         intr     <= 1'b0;
      end else begin
         edgePrev <= edgeSrc;
         intr     <= edgeSrc & ~edgePrev;
      end
   end

   // Memory-mapped write registers. Only an exact address match updates a
   // register; writes anywhere else are silently dropped.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         ledReg    <= '0;
         dispValue <= '0;
      end else if (iobusWr) begin
         if (iobusAddr == LedAddr) begin
            ledReg <= iobusOut[7:0];
         end else if (iobusAddr == SsegAddr) begin
            dispValue <= iobusOut[15:0];
         end
      end
   end

   assign LEDS = ledReg;

   // Combinational read mux: only the switch address returns data, every
   // other address reads as zero.
   always_comb begin
      iobusIn = '0;
      if (iobusAddr == SwitchAddr) begin
         iobusIn = {24'b0, swSync};
      end
   end

   OTTER_MCU mcu (
      .CLK        (CLK),
      .RST        (reset),
      .INTR       (intr),
      .IOBUS_IN   (iobusIn),
      .IOBUS_OUT  (iobusOut),
      .IOBUS_ADDR (iobusAddr),
      .IOBUS_WR   (iobusWr)
   );

   sseg_driver #(
      .REFRESH_BITS (REFRESH_BITS)
   ) ssegDriver (
      .CLK      (CLK),
      .reset    (reset),
      .value    (dispValue),
      .CATHODES (CATHODES),
      .ANODES   (ANODES)
   );

endmodule

// File: tb/tb_otter_io_wrapper.sv
// tb_otter_io_wrapper
// Scoreboard bench for otter_io_wrapper with a 4-bit scan counter and no
// debounce. Stimulus pushes expected LED, read-data and interrupt responses
// (tagged with the cycle they are due) into a queue; a monitor on the falling
// edge pops and compares them, checks INTR every cycle and compares the
// display against a frame-position model derived from the reset release time.
module tb_otter_io_wrapper;

   localparam int RefreshBits  = 4;
   localparam int FrameCycles  = 1 << RefreshBits;
   localparam int DigitCycles  = 1 << (RefreshBits - 2);
   localparam int Never        = 32'h3FFF_FFFF;
   localparam logic [31:0] SwitchAddrTb = 32'h1100_0000;
   localparam logic [31:0] LedAddrTb    = 32'h1108_0000;
   localparam logic [31:0] SsegAddrTb   = 32'h110C_0000;

   typedef enum { KindLeds, KindBusIn, KindIntr } kind_e;
   typedef enum { OpWrite, OpRead, OpPress, OpResetMidPress } op_e;
   typedef struct {
      int          cycle;
      kind_e       kind;
      logic [31:0] data;
   } expect_t;

   logic        clk;
   logic        btnc;
   logic        btnl;
   logic [7:0]  switches;
   logic [7:0]  leds;
   logic [7:0]  cathodes;
   logic [3:0]  anodes;
   logic [31:0] busAddr;
   logic [31:0] busOut;
   logic        busWr;

   int checks     = 0;
   int errors     = 0;
   int cycleCount = 0;

   expect_t     sbQ[$];
   logic [7:0]  segTable [16];
   logic [7:0]  ledModel;
   logic [7:0]  switchModel;
   logic [15:0] dispOld;
   logic [15:0] dispNew;
   int          dispChange;
   int          releaseCycle;

   otter_io_wrapper #(
      .REFRESH_BITS    (RefreshBits),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .CLK      (clk),
      .BTNC     (btnc),
      .BTNL     (btnl),
      .SWITCHES (switches),
      .LEDS     (leds),
      .CATHODES (cathodes),
      .ANODES   (anodes)
   );

   // 100 MHz-style free-running clock; only relative timing matters here.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle index used to tag when each expected response is due.
   always @(posedge clk) begin
      cycleCount++;
   end

   // Hard stop in case something wedges the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)",
                  name, actual, expected, cycleCount);
      end
   endtask

   task automatic pushExpect(input int cycle, input kind_e kind, input logic [31:0] data);
      expect_t item;
      item.cycle = cycle;
      item.kind  = kind;
      item.data  = data;
      sbQ.push_back(item);
   endtask

   task automatic driveBus();
      force dut.iobusAddr = busAddr;
      force dut.iobusOut  = busOut;
      force dut.iobusWr   = busWr;
   endtask

   function automatic logic [15:0] currentDisp();
      return (cycleCount >= dispChange) ? dispNew : dispOld;
   endfunction

   function automatic logic [31:0] randomOtherAddr();
      logic [31:0] a;
      case ($urandom_range(0, 2))
         0:       a = SwitchAddrTb + 32'($urandom_range(1, 64)) * 4;
         1:       a = 32'($urandom_range(0, 32'h0FFF_FFFF));
         default: a = SsegAddrTb;
      endcase
      return a;
   endfunction

   // Expected {ANODES, CATHODES}: blank while BTNC is low or before internal
   // reset releases; afterwards the frame position is simply the number of
   // cycles since release, and each digit covers DigitCycles of it.
   function automatic logic [11:0] expectDisplay(input int c);
      logic [15:0] v;
      logic [3:0]  an;
      logic [3:0]  nib;
      int          sel;
      if (btnc == 1'b0 || c < releaseCycle) begin
         return 12'hFFF;
      end
      v   = (c >= dispChange) ? dispNew : dispOld;
      sel = ((c - releaseCycle) % FrameCycles) / DigitCycles;
      an  = 4'hF;
      an[sel] = 1'b0;
      nib = v[4*sel +: 4];
      return {an, segTable[nib]};
   endfunction

   // Monitor: on every falling edge, retire all scoreboard entries due this
   // cycle, check INTR against whether a pulse was due, and check the display.
   always @(negedge clk) begin : monitor
      bit          intrDue;
      logic [11:0] disp;
      intrDue = 1'b0;
      for (int i = sbQ.size() - 1; i >= 0; i--) begin
         if (sbQ[i].cycle == cycleCount) begin
            case (sbQ[i].kind)
               KindLeds:  checkOutput("leds", {24'b0, leds}, sbQ[i].data);
               KindBusIn: checkOutput("iobus_in", dut.iobusIn, sbQ[i].data);
               KindIntr:  intrDue = 1'b1;
            endcase
            sbQ.delete(i);
         end
      end
      checkOutput("intr", {31'b0, dut.intr}, {31'b0, intrDue});
      disp = expectDisplay(cycleCount);
      checkOutput("display", {20'b0, anodes, cathodes}, {20'b0, disp});
   end

   task automatic applyStimulus(input op_e op, input logic [31:0] addr,
                                input logic [31:0] data);
      int         c;
      logic [7:0] prevSw;
      @(posedge clk);
      #2;
      c = cycleCount;
      case (op)
         OpWrite: begin
            busAddr = addr;
            busOut  = data;
            busWr   = 1'b1;
            driveBus();
            if (addr == LedAddrTb) begin
               ledModel = data[7:0];
            end
            if (addr == SsegAddrTb) begin
               dispOld    = currentDisp();
               dispNew    = data[15:0];
               dispChange = c + 1;
            end
            pushExpect(c + 1, KindLeds, {24'b0, ledModel});
            @(posedge clk);
            #2;
            busWr = 1'b0;
            driveBus();
         end
         OpRead: begin
            busAddr = addr;
            driveBus();
            prevSw      = switchModel;
            switches    = data[7:0];
            switchModel = data[7:0];
            if (addr == SwitchAddrTb) begin
               pushExpect(c + 1, KindBusIn, {24'b0, prevSw});
               pushExpect(c + 2, KindBusIn, {24'b0, switchModel});
            end else begin
               pushExpect(c + 1, KindBusIn, 32'h0);
               pushExpect(c + 2, KindBusIn, 32'h0);
            end
            repeat (2) @(posedge clk);
         end
         OpPress: begin
            btnl = 1'b1;
            pushExpect(c + 3, KindIntr, 32'h1);
            repeat (data) @(posedge clk);
            #2;
            btnl = 1'b0;
            repeat (4) @(posedge clk);
         end
         OpResetMidPress: begin
            btnl = 1'b1;
            repeat (2) @(posedge clk);
            #2;
            btnc         = 1'b0;
            ledModel     = 8'h00;
            dispOld      = 16'h0;
            dispNew      = 16'h0;
            dispChange   = 0;
            releaseCycle = Never;
            #1;
            checkOutput("async reset leds", {24'b0, leds}, 32'h0);
            checkOutput("async reset anodes", {28'b0, anodes}, 32'hF);
            checkOutput("async reset cathodes", {24'b0, cathodes}, 32'hFF);
            checkOutput("async reset intr", {31'b0, dut.intr}, 32'h0);
            btnl = 1'b0;
            repeat (3) @(posedge clk);
            #2;
            btnc         = 1'b1;
            releaseCycle = cycleCount + 2;
            repeat (6) @(posedge clk);
         end
      endcase
   endtask

   initial begin
      segTable = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                   8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
      btnc         = 1'b1;
      btnl         = 1'b0;
      switches     = 8'h00;
      busAddr      = 32'h0;
      busOut       = 32'h0;
      busWr        = 1'b0;
      driveBus();
      ledModel     = 8'h00;
      switchModel  = 8'h00;
      dispOld      = 16'h0;
      dispNew      = 16'h0;
      dispChange   = 0;
      releaseCycle = Never;

      #1 btnc = 1'b0;
      #1;
      checkOutput("reset leds", {24'b0, leds}, 32'h0);
      checkOutput("reset anodes", {28'b0, anodes}, 32'hF);
      checkOutput("reset cathodes", {24'b0, cathodes}, 32'hFF);
      checkOutput("reset intr", {31'b0, dut.intr}, 32'h0);
      repeat (3) @(posedge clk);
      #2;
      btnc         = 1'b1;
      releaseCycle = cycleCount + 2;
      repeat (4) @(posedge clk);

      $display("[TB] LED writes");
      applyStimulus(OpWrite, LedAddrTb, 32'h0000_00A5);
      applyStimulus(OpWrite, LedAddrTb + 32'h4, $urandom);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(OpWrite, LedAddrTb, $urandom);
      end

      $display("[TB] Switch reads");
      applyStimulus(OpRead, SwitchAddrTb, 32'h0000_003C);
      applyStimulus(OpRead, randomOtherAddr(), $urandom);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(OpRead, ($urandom_range(0, 1) == 0) ? SwitchAddrTb : randomOtherAddr(),
                       $urandom);
      end

      $display("[TB] Display writes");
      applyStimulus(OpWrite, SsegAddrTb, 32'h0000_12EF);
      repeat (FrameCycles + 4) @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(OpWrite, SsegAddrTb, $urandom);
         repeat (FrameCycles + 4) @(posedge clk);
      end
      applyStimulus(OpWrite, SsegAddrTb + 32'h4, $urandom);
      repeat (FrameCycles) @(posedge clk);

      $display("[TB] Interrupt presses");
      applyStimulus(OpPress, 32'h0, 32'd10);
      applyStimulus(OpPress, 32'h0, 32'd10);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(OpPress, 32'h0, 32'($urandom_range(4, 12)));
      end

      $display("[TB] Reset mid-press");
      applyStimulus(OpWrite, LedAddrTb, 32'h0000_005A);
      applyStimulus(OpWrite, SsegAddrTb, 32'h0000_BEEF);
      repeat (3) @(posedge clk);
      applyStimulus(OpResetMidPress, 32'h0, 32'h0);

      $display("[TB] Operation after reset");
      applyStimulus(OpWrite, LedAddrTb, $urandom);
      applyStimulus(OpRead, SwitchAddrTb, $urandom);
      applyStimulus(OpPress, 32'h0, 32'd6);
      repeat (8) @(posedge clk);
      #2;

      checkOutput("scoreboard drained", 32'(sbQ.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/otter_io_wrapper.md
# otter_io_wrapper

Board-level wrapper that sits between the existing `OTTER_MCU` RISC-V core and the FPGA board pins. It provides:
- reset conditioning;
- a BTNL interrupt conditioner;
- memory-mapped I/O registers for switches, LEDs and a 16-bit seven-segment value;
- a multiplexed 4-digit hex seven-segment driver.

The design top instantiates it as `OTTER_Wrapper_Programmable`.

## Interface
Parameters:
- `REFRESH_BITS`, default 17: width of the display scan counter; its top 2 bits select the digit.
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable cycles BTNL needs (only used with debounce).

Ports:
- `CLK`  in  1: system clock (50 MHz). One clock; reset is asynchronous and active-low.
- `BTNC`  in  1: reset, asynchronous, active-low.
- `BTNL`  in  1: interrupt button, active-high, asynchronous to `CLK`.
- `SWITCHES`  in  8: slide switches.
- `LEDS`  out  8: LED outputs.
- `CATHODES`  out  8: segment lines, active-low, bit order {a,b,c,d,e,f,g,dp}, with `CATHODES[7]`=a.
- `ANODES`  out  4: digit enables, active-low; `ANODES[0]` is the rightmost digit.

## Operation
- **Reset:** `BTNC`=0 asserts the internal reset immediately. Deassertion is synchronized through 2 flops. The MCU reset input is the active-high internal reset.
- **MCU hookup:** `OTTER_MCU` ports `CLK`, `RST`, `INTR`, `IOBUS_IN[31:0]`, `IOBUS_OUT[31:0]`, `IOBUS_ADDR[31:0]`, `IOBUS_WR`.
- **Address map** (exact 32-bit match):
  - 0x11000000: switches (read).
  - 0x11080000: LEDs (write, `IOBUS_OUT[7:0]`).
  - 0x110C0000: display value (write, `IOBUS_OUT[15:0]`).
- **IOBUS_IN read mux:** combinational. 0x11000000 returns {24'b0, synchronized SWITCHES}; any other address returns 0.
- **Writes:** a write at an unmapped address has no effect.
- **Switch sampling:** `SWITCHES` passes through a 2-flop synchronizer.
- **Interrupt path:** `BTNL` goes through a 2-flop synchronizer, then optional debounce, then a rising-edge one-shot. The one-shot drives `INTR` high for exactly 1 cycle per press. Holding the button produces no further pulses.
- **Display:**
  - The scan counter increments every cycle.
  - `sel = cnt[REFRESH_BITS-1:REFRESH_BITS-2]`. Digit `sel` shows nibble `value[4*sel+3:4*sel]`; sel 0 is the rightmost digit (`ANODES`=4'b1110).
  - All 4 digits are always shown in hex, with no leading-zero blanking. The dp segment is always off.
- **Hex encodings** (`CATHODES`): 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, A=11, B=C1, C=63, D=85, E=61, F=71.

## Timing
Reset values of outputs and state:
- `LEDS`=0; display value=0; scan counter=0; synchronizers and one-shot=0; `INTR`=0.
- Display outputs during reset: `ANODES`=4'hF, `CATHODES`=8'hFF (blank).

Latencies:
- **LED / display writes:** a write registers on the rising edge where `IOBUS_WR`=1. `LEDS` change right after that edge (0-cycle combinational path from the register). The display shows the new value from the next scan of each digit.
- **Switch reads:** a `SWITCHES` change is visible in `IOBUS_IN` 2 edges later.
- **Interrupt, no debounce:** `INTR` rises after the 3rd rising edge that samples `BTNL`=1 and stays high for 1 cycle.
- **Interrupt, with debounce:** add `DEBOUNCE_CYCLES` cycles.
- **Digit dwell:** each digit is held for 2^(`REFRESH_BITS`-2) cycles. The 4-digit frame then wraps.

Boundary conditions:
- A simultaneous write to LED and display addresses cannot occur (one address per cycle).
- Reset asserted mid-press cancels any pending `INTR`.
- Reset asserted mid-scan immediately blanks the display.

## Configuration
- `BTN_DEBOUNCE_EN` defined: the synchronized `BTNL` must be stable for `DEBOUNCE_CYCLES` consecutive cycles before the debounced level changes. The one-shot edge-detects the debounced level.
- `BTN_DEBOUNCE_EN` undefined: the one-shot edge-detects the synchronized `BTNL` directly. No debounce counter is built; this is the default for simulation.

## Structure
- Package `otter_io_pkg`: the three address constants and the 16-entry hex-to-cathode lookup function.
- Sub-module `sseg_driver` (`CLK`, reset, `value[15:0]`, `CATHODES`, `ANODES`; parameter `REFRESH_BITS`). It owns the scan counter and decode.
- The wrapper itself holds reset sync, the interrupt conditioner, MMIO registers, the read mux and the MCU instance.

## Test plan
For simulation, set `REFRESH_BITS`=4 and leave `BTN_DEBOUNCE_EN` undefined.
- **Reset:** hold `BTNC`=0 → `LEDS`=00, `ANODES`=F, `CATHODES`=FF, `INTR`=0. Release → the display starts scanning "0000" with `CATHODES`=03.
- **LED write:** force a bus write of 0x000000A5 to 0x11080000 → `LEDS`=A5 after that edge. A write to 0x11080004 → `LEDS` unchanged.
- **Switch read:** `SWITCHES`=0x3C; after 2 edges, `IOBUS_ADDR`=0x11000000 → `IOBUS_IN`=0x0000003C. Any other address → 0.
- **Display write:** write 0x12EF to 0x110C0000 → the scan cycles `ANODES` E,D,B,7 with `CATHODES` 71,61,25,9F.
- **Interrupt:** hold `BTNL` high for 10 cycles → `INTR` high for exactly 1 cycle, 3 edges after the rise. A second press gives a second pulse.
- **Reset mid-operation:** `BTNC`=0 between cycles → outputs immediately return to their reset values, and `LEDS` clears without waiting for a clock edge.
